load_store_unit: RTL
====================

// Module: load_store_unit
// PURPOSE
//  Data-memory access stage directly downstream of the ALU. Takes the ALU result as the effective
//  address plus rs2 store data. Issues one word-aligned request on a req/ack memory port.
//  Returns sign- or zero-extended load data with an error code, and drives busy to stall the core.
// PARAMETERS
//  WIDTH    32  datapath/address width; only 32 is supported (4 byte lanes)
//  TIMEOUT  16  REQ cycles without mem_ack before the bus-timeout error; 0 disables the timeout
// PORTS
//  clk         in   1      single clock, all state updates on rising edge
//  rst         in   1      synchronous, active-high reset
//  req_valid   in   1      core presents an access this cycle
//  req_ready   out  1      unit can accept; equals (state==IDLE)
//  req_store   in   1      1=store, 0=load
//  req_funct3  in   3      RV32I funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU; 011/110/111 illegal
//  req_addr    in   WIDTH  effective address (ALU result)
//  req_wdata   in   WIDTH  store data (rs2)
//  resp_valid  out  1      one-cycle completion pulse
//  resp_rdata  out  WIDTH  extended load data; 0 for stores and errors
//  resp_err    out  2      00 ok, 01 misaligned, 10 timeout, 11 illegal funct3
//  busy        out  1      state != IDLE
//  mem_req     out  1      memory request, held until ack or timeout
//  mem_we      out  1      write enable
//  mem_addr    out  WIDTH  {req_addr[31:2],2'b00}
//  mem_be      out  4      byte enables
//  mem_wdata   out  WIDTH  lane-replicated store data
//  mem_ack     in   1      memory completes the access this cycle
//  mem_rdata   in   WIDTH  read word; valid when mem_ack=1
// BEHAVIOUR
//  - Reset: state IDLE, timeout count 0. req_ready=1. All other outputs 0.
//  - Reset mid-access abandons the access. mem_req drops at that edge and no resp_valid is produced.
//  - States: IDLE -> REQ -> RESP -> IDLE. Errored requests go IDLE -> RESP.
//  - Accept on the edge where req_valid & req_ready. Address, funct3, store flag, offset and data are latched.
//  - Check order at accept: illegal funct3 gives err 11; otherwise misalignment gives err 01.
//    Misaligned means: H/HU with addr[0]=1, or W with addr[1:0]!=0.
//    Errored requests make no memory access. resp_valid comes 1 cycle after accept.
//  - mem_be by size: B = 4'b0001<<addr[1:0]; H = 4'b0011<<addr[1:0]; W = 4'b1111.
//  - mem_wdata by size: B = {4{wdata[7:0]}}; H = {2{wdata[15:0]}}; W = wdata.
//  - REQ: mem_req=1 and mem_we/addr/be/wdata are held stable every cycle until mem_ack is sampled high.
//  - On ack: capture mem_rdata and select the lane by the latched offset.
//    funct3[2]=0 sign-extends; funct3[2]=1 zero-extends. Stores return 0.
//  - Next cycle: state RESP, mem_req=0, resp_valid=1 for exactly one cycle, then IDLE.
//  - Best-case latency: accept at edge 0, ack sampled at edge 1, resp_valid in cycle 2.
//  - Timeout: counter clears on entering REQ and increments each REQ cycle without ack.
//    At count==TIMEOUT-1 with no ack: go to RESP with err 10 and rdata 0.
//    Ack in the same cycle as the limit wins: completes normally.
//  - mem_ack outside REQ is ignored.
//  - req_ready=0 in REQ and RESP. The next request is accepted no earlier than the cycle after RESP.
//  - resp_rdata and resp_err hold their value until the next RESP.
// STRUCTURE
//  - Shared header lsu_defs.vh: state encodings, funct3 constants, error codes.
//  - Sub-module lsu_load_align (combinational): lane select plus sign/zero extend from (rdata, offset, funct3).
//  - Top level holds FSM, request latches, byte-enable/replication logic and timeout counter.
// TESTING
//  1. LW addr=0x100, ack 1 cycle later, rdata=0xDEADBEEF
//     -> mem_addr=0x100, be=1111, resp_rdata=0xDEADBEEF, err=00, resp_valid 2 cycles after accept
//  2. LB addr=0x103, rdata=0x80112233 -> be=1000, resp_rdata=0xFFFFFF80;
//     same with LBU -> 0x00000080
//  3. SH addr=0x202, wdata=0x0000ABCD -> mem_we=1, be=1100, mem_wdata=0xABCDABCD;
//     mem_req held across 3 wait cycles until ack
//  4. LW addr=0x101 -> no mem_req, err=01, resp_valid 1 cycle after accept;
//     funct3=011 -> err=11
//  5. TIMEOUT=4, LW with no ack -> mem_req high for 4 cycles, then err=10, rdata=0;
//     separately, ack on the 4th cycle -> err=00
//  6. rst asserted during REQ -> mem_req=0 and busy=0 after that edge, no resp_valid;
//     next request completes normally

Source files
------------

// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit: FSM states, funct3 codes, error codes
// and the request-side lane helpers used when an access is accepted.
package load_store_unit_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_RESP = 2'b10
    } lsu_state_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] ERR_OK       = 2'b00;
    localparam logic [1:0] ERR_MISALIGN = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT  = 2'b10;
    localparam logic [1:0] ERR_ILLEGAL  = 2'b11;

    function automatic logic f3_illegal(input logic [2:0] f3);
        case (f3)
            F3_B, F3_H, F3_W, F3_BU, F3_HU: return 1'b0;
            default:                        return 1'b1;
        endcase
    endfunction

    // size is funct3[1:0]: 00 byte, 01 half, 10 word
    function automatic logic size_misaligned(input logic [1:0] size, input logic [1:0] off);
        case (size)
            2'b01:   return off[0];
            2'b10:   return (off != 2'b00);
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] byte_enables(input logic [1:0] size, input logic [1:0] off);
        case (size)
            2'b00:   return 4'b0001 << off;
            2'b01:   return 4'b0011 << off;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] store_lanes(input logic [1:0] size, input logic [31:0] wdata);
        case (size)
            2'b00:   return {4{wdata[7:0]}};
            2'b01:   return {2{wdata[15:0]}};
            default: return wdata;
        endcase
    endfunction

endpackage

// File: rtl/load_store_unit_load_align.sv
// Combinational load-data alignment: picks the addressed byte/half out of the read word
// and sign- or zero-extends it according to funct3.
module load_store_unit_load_align
    import load_store_unit_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  offset,
    input  logic [2:0]  funct3,
    output logic [31:0] data
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;
    logic        zext_s;

    assign zext_s = funct3[2];

    // Lane select and extension
    always_comb begin
        byte_s = 8'h00;
        half_s = 16'h0000;
        data   = 32'h0000_0000;
        case (offset)
            2'b00:   byte_s = rdata[7:0];
            2'b01:   byte_s = rdata[15:8];
            2'b10:   byte_s = rdata[23:16];
            2'b11:   byte_s = rdata[31:24];
            default: byte_s = 8'h00;
        endcase
        if (offset[1]) begin
            half_s = rdata[31:16];
        end else begin
            half_s = rdata[15:0];
        end
        case (funct3[1:0])
            2'b00:   data = zext_s ? {24'h000000, byte_s} : {{24{byte_s[7]}}, byte_s};
            2'b01:   data = zext_s ? {16'h0000, half_s}   : {{16{half_s[15]}}, half_s};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Data-memory access stage: accepts one load/store from the core, runs it over a req/ack
// memory port with an optional bus timeout, and returns aligned load data plus an error code.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_store,
    input  logic [2:0]       req_funct3,
    input  logic [WIDTH-1:0] req_addr,
    input  logic [WIDTH-1:0] req_wdata,
    output logic             resp_valid,
    output logic [WIDTH-1:0] resp_rdata,
    output logic [1:0]       resp_err,
    output logic             busy,
    output logic             mem_req,
    output logic             mem_we,
    output logic [WIDTH-1:0] mem_addr,
    output logic [3:0]       mem_be,
    output logic [WIDTH-1:0] mem_wdata,
    input  logic             mem_ack,
    input  logic [WIDTH-1:0] mem_rdata
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    lsu_state_e      state_r, state_s;
    logic [CW-1:0]   tcnt_r;
    logic [1:0]      off_r;
    logic [2:0]      f3_r;
    logic            store_r;
    logic            mem_we_r;
    logic [WIDTH-1:0] mem_addr_r;
    logic [3:0]      mem_be_r;
    logic [WIDTH-1:0] mem_wdata_r;
    logic [WIDTH-1:0] resp_rdata_r;
    logic [1:0]      resp_err_r;

    logic            accept_s;
    logic [1:0]      req_err_s;
    logic            timeout_s;
    logic [31:0]     load_data_s;

    assign accept_s  = req_valid && (state_r == ST_IDLE);
    assign timeout_s = (TIMEOUT != 0) && (state_r == ST_REQ) && !mem_ack
                       && (tcnt_r == CW'(TIMEOUT - 1));

    // Accept-time checks: an illegal funct3 masks any alignment problem
    always_comb begin
        req_err_s = ERR_OK;
        if (f3_illegal(req_funct3)) begin
            req_err_s = ERR_ILLEGAL;
        end else if (size_misaligned(req_funct3[1:0], req_addr[1:0])) begin
            req_err_s = ERR_MISALIGN;
        end else begin
            req_err_s = ERR_OK;
        end
    end

    // Next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_s = (req_err_s != ERR_OK) ? ST_RESP : ST_REQ;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (mem_ack || timeout_s) begin
                    state_s = ST_RESP;
                end else begin
                    state_s = ST_REQ;
                end
            end
            ST_RESP: state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // State register and wait-cycle counter (counter sits at 0 outside REQ)
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            tcnt_r  <= '0;
        end else begin
            state_r <= state_s;
            if (state_r != ST_REQ) begin
                tcnt_r <= '0;
            end else if (!mem_ack) begin
                tcnt_r <= tcnt_r + CW'(1);
            end
        end
    end

    load_store_unit_load_align u_align (
        .rdata  (mem_rdata),
        .offset (off_r),
        .funct3 (f3_r),
        .data   (load_data_s)
    );

    // Request latches, memory-port drive registers and the held response
    always_ff @(posedge clk) begin
        if (rst) begin
            off_r        <= 2'b00;
            f3_r         <= 3'b000;
            store_r      <= 1'b0;
            mem_we_r     <= 1'b0;
            mem_addr_r   <= '0;
            mem_be_r     <= 4'b0000;
            mem_wdata_r  <= '0;
            resp_rdata_r <= '0;
            resp_err_r   <= ERR_OK;
        end else begin
            if (accept_s) begin
                off_r   <= req_addr[1:0];
                f3_r    <= req_funct3;
                store_r <= req_store;
                if (req_err_s == ERR_OK) begin
                    mem_we_r    <= req_store;
                    mem_addr_r  <= {req_addr[WIDTH-1:2], 2'b00};
                    mem_be_r    <= byte_enables(req_funct3[1:0], req_addr[1:0]);
                    mem_wdata_r <= store_lanes(req_funct3[1:0], req_wdata);
                end else begin
                    resp_err_r   <= req_err_s;
                    resp_rdata_r <= '0;
                end
            end else if (state_r == ST_REQ) begin
                if (mem_ack) begin
                    resp_err_r   <= ERR_OK;
                    resp_rdata_r <= store_r ? '0 : load_data_s;
                end else if (timeout_s) begin
                    resp_err_r   <= ERR_TIMEOUT;
                    resp_rdata_r <= '0;
                end
            end
        end
    end

    assign req_ready  = (state_r == ST_IDLE);
    assign busy       = (state_r != ST_IDLE);
    assign mem_req    = (state_r == ST_REQ);
    assign resp_valid = (state_r == ST_RESP);
    assign mem_we     = mem_we_r;
    assign mem_addr   = mem_addr_r;
    assign mem_be     = mem_be_r;
    assign mem_wdata  = mem_wdata_r;
    assign resp_rdata = resp_rdata_r;
    assign resp_err   = resp_err_r;

endmodule
